reaction_session_ctrl: RTL and testbench

Session sequencer for the reaction_timer block. It runs a fixed number of reaction rounds from a single user button: it clears and starts the timer, forwards the button as the timer's stop, and collects each round's BCD result. It keeps best-time and fail/success statistics for the OLED/seven-seg display layer, and sits between the debounced button and reaction_timer in the top level.

---
 rtl/reaction_session_ctrl.sv | 172 +++++++++++++++++
 tb/tb_reaction_session_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_session_ctrl.sv
// Session sequencer wrapped around reaction_timer: runs ROUNDS rounds from one button and keeps best/ok/fail stats.
// Optional REACTION_AUTO_RETRY_EN: early results replay the same round instead of consuming it.
module reaction_session_ctrl #(
    parameter int ROUNDS     = 5,
    parameter int HOLD_TICKS = 200000000,
    parameter int CNT_W      = 32
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_btn,
    input  logic [1:0]  i_timer_state,
    input  logic [1:0]  i_timer_fail,
    input  logic [15:0] i_timer_bcd,
    output logic        o_timer_clr,
    output logic        o_start,
    output logic        o_stop,
    output logic [3:0]  o_round,
    output logic [15:0] o_last_bcd,
    output logic [15:0] o_best_bcd,
    output logic [3:0]  o_ok_cnt,
    output logic [3:0]  o_fail_cnt,
    output logic [2:0]  o_ctrl_state,
    output logic        o_session_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLR   = 3'd1,
        S_START = 3'd2,
        S_RUN   = 3'd3,
        S_LATCH = 3'd4,
        S_HOLD  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [15:0] BEST_INIT = 16'h9999;
    localparam logic [1:0]  TIMER_DONE = 2'b11;

    state_t             r_state;
    state_t             w_next;
    logic               r_btn_q;
    logic               w_btn_rise;
    logic               r_clr_wait;
    logic [CNT_W-1:0]   r_hold_cnt;
    logic               w_hold_done;
    logic               w_last_round;
    logic               w_replay;
    logic               r_timer_clr;
    logic               r_start;
    logic               r_stop;
    logic [3:0]         r_round;
    logic [15:0]        r_last_bcd;
    logic [15:0]        r_best_bcd;
    logic [3:0]         r_ok_cnt;
    logic [3:0]         r_fail_cnt;

    assign w_btn_rise   = i_btn & ~r_btn_q;
    assign w_hold_done  = (r_hold_cnt == CNT_W'(HOLD_TICKS - 1));
    assign w_last_round = (r_round == 4'(ROUNDS));

`ifdef REACTION_AUTO_RETRY_EN
    logic r_early;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_early <= 1'b0;
        else if (r_state == S_LATCH)
            r_early <= (i_timer_fail == 2'd1);
    end

    assign w_replay = r_early;
`else
    assign w_replay = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next;
    end

    // NOTE: w_next gets its default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_btn_rise) w_next = S_CLR;
            S_CLR:   if (r_clr_wait) w_next = S_START;
            S_START: w_next = S_RUN;
            S_RUN:   if (i_timer_state == TIMER_DONE) w_next = S_LATCH;
            S_LATCH: w_next = S_HOLD;
            S_HOLD: begin
                if (w_hold_done)
                    w_next = (w_last_round && !w_replay) ? S_DONE : S_CLR;
            end
            S_DONE:  if (w_btn_rise) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // S_CLR dwells two cycles so o_start trails o_timer_clr by two clocks.
    // NOTE: all sequential state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btn_q     <= 1'b0;
            r_clr_wait  <= 1'b0;
            r_timer_clr <= 1'b0;
            r_start     <= 1'b0;
            r_stop      <= 1'b0;
            r_hold_cnt  <= '0;
            r_round     <= 4'd0;
            r_last_bcd  <= 16'h0000;
            r_best_bcd  <= BEST_INIT;
            r_ok_cnt    <= 4'd0;
            r_fail_cnt  <= 4'd0;
        end else begin
            r_btn_q     <= i_btn;
            r_clr_wait  <= (r_state == S_CLR) && !r_clr_wait;
            r_timer_clr <= (r_state == S_CLR) && !r_clr_wait;
            r_start     <= (r_state == S_START);
            r_stop      <= (r_state == S_RUN) && w_btn_rise;

            case (r_state)
                S_IDLE: begin
                    if (w_btn_rise) begin
                        r_round    <= 4'd1;
                        r_last_bcd <= 16'h0000;
                        r_best_bcd <= BEST_INIT;
                        r_ok_cnt   <= 4'd0;
                        r_fail_cnt <= 4'd0;
                    end
                end
                S_LATCH: begin
                    r_last_bcd <= i_timer_bcd;
                    r_hold_cnt <= '0;
                    if (i_timer_fail == 2'd0) begin
                        if (r_ok_cnt != 4'hF)
                            r_ok_cnt <= r_ok_cnt + 4'd1;
                        // Packed BCD digits order the same as plain unsigned binary.
                        if (i_timer_bcd < r_best_bcd)
                            r_best_bcd <= i_timer_bcd;
                    end else if (r_fail_cnt != 4'hF) begin
                        r_fail_cnt <= r_fail_cnt + 4'd1;
                    end
                end
                S_HOLD: begin
                    if (!w_hold_done)
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    else if (!w_replay && !w_last_round && r_round != 4'hF)
                        r_round <= r_round + 4'd1;
                end
                S_DONE: begin
                    if (w_btn_rise)
                        r_round <= 4'd0;
                end
                default: ;
            endcase
        end
    end

    assign o_timer_clr    = r_timer_clr;
    assign o_start        = r_start;
    assign o_stop         = r_stop;
    assign o_round        = r_round;
    assign o_last_bcd     = r_last_bcd;
    assign o_best_bcd     = r_best_bcd;
    assign o_ok_cnt       = r_ok_cnt;
    assign o_fail_cnt     = r_fail_cnt;
    assign o_ctrl_state   = r_state;
    assign o_session_done = (r_state == S_DONE);

endmodule

// File: tb/tb_reaction_session_ctrl.sv
// Directed bench for reaction_session_ctrl; the reaction_timer outputs are driven by hand from the stimulus.
// Build with REACTION_AUTO_RETRY_EN defined to exercise the replay-on-early session instead of the default one.
module tb_reaction_session_ctrl;

`ifdef REACTION_AUTO_RETRY_EN
    localparam int ROUNDS = 2;
`else
    localparam int ROUNDS = 3;
`endif
    localparam int HOLD_TICKS = 10;
    localparam int CNT_W      = 32;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_btn;
    logic [1:0]  i_timer_state;
    logic [1:0]  i_timer_fail;
    logic [15:0] i_timer_bcd;
    logic        o_timer_clr;
    logic        o_start;
    logic        o_stop;
    logic [3:0]  o_round;
    logic [15:0] o_last_bcd;
    logic [15:0] o_best_bcd;
    logic [3:0]  o_ok_cnt;
    logic [3:0]  o_fail_cnt;
    logic [2:0]  o_ctrl_state;
    logic        o_session_done;

    int n_tests = 0;
    int n_fail  = 0;
    int n_stops = 0;

    reaction_session_ctrl #(
        .ROUNDS     (ROUNDS),
        .HOLD_TICKS (HOLD_TICKS),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk          (clk),
        .i_reset        (i_reset),
        .i_btn          (i_btn),
        .i_timer_state  (i_timer_state),
        .i_timer_fail   (i_timer_fail),
        .i_timer_bcd    (i_timer_bcd),
        .o_timer_clr    (o_timer_clr),
        .o_start        (o_start),
        .o_stop         (o_stop),
        .o_round        (o_round),
        .o_last_bcd     (o_last_bcd),
        .o_best_bcd     (o_best_bcd),
        .o_ok_cnt       (o_ok_cnt),
        .o_fail_cnt     (o_fail_cnt),
        .o_ctrl_state   (o_ctrl_state),
        .o_session_done (o_session_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_stop) n_stops++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Waits for the clear pulse, resets the timer model, then expects o_start two clocks later.
    task automatic start_round(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < HOLD_TICKS + 20 && !seen; k++) begin
            tick();
            if (o_timer_clr) seen = 1'b1;
        end
        check({tag, " clr seen"}, 32'(seen), 32'd1);
        i_timer_state = 2'b00;
        tick();
        check({tag, " start +1"}, 32'(o_start), 32'd0);
        tick();
        check({tag, " start +2"}, 32'(o_start), 32'd1);
        check({tag, " run state"}, 32'(o_ctrl_state), 32'd3);
    endtask

    task automatic press_stop(input string tag);
        check({tag, " stop idle"}, 32'(o_stop), 32'd0);
        i_btn = 1'b1;
        tick();
        check({tag, " stop +1"}, 32'(o_stop), 32'd1);
        tick();
        check({tag, " stop width"}, 32'(o_stop), 32'd0);
    endtask

    // Timer reports done; leaves the bench one cycle into S_HOLD.
    task automatic finish_round(input string tag, input logic [1:0] fail, input logic [15:0] bcd);
        i_timer_state = 2'b11;
        i_timer_fail  = fail;
        i_timer_bcd   = bcd;
        tick();
        check({tag, " latch state"}, 32'(o_ctrl_state), 32'd4);
        tick();
        check({tag, " hold state"}, 32'(o_ctrl_state), 32'd5);
        check({tag, " last bcd"}, 32'(o_last_bcd), 32'(bcd));
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int k = 0; k < HOLD_TICKS + 5 && !seen; k++) begin
            tick();
            if (o_session_done) seen = 1'b1;
        end
        check({tag, " done seen"}, 32'(seen), 32'd1);
        check({tag, " done state"}, 32'(o_ctrl_state), 32'd6);
    endtask

    task automatic begin_session(input string tag);
        i_btn = 1'b1;
        tick();
        check({tag, " round 1"}, 32'(o_round), 32'd1);
        check({tag, " clr state"}, 32'(o_ctrl_state), 32'd1);
        check({tag, " best init"}, 32'(o_best_bcd), 32'h9999);
        check({tag, " ok zero"}, 32'(o_ok_cnt), 32'd0);
        check({tag, " fail zero"}, 32'(o_fail_cnt), 32'd0);
        i_btn = 1'b0;
    endtask

    initial begin
        int s0;
        i_reset       = 1'b1;
        i_btn         = 1'b0;
        i_timer_state = 2'b00;
        i_timer_fail  = 2'd0;
        i_timer_bcd   = 16'h0000;
        tick();
        tick();
        check("rst state", 32'(o_ctrl_state), 32'd0);
        check("rst round", 32'(o_round), 32'd0);
        check("rst best", 32'(o_best_bcd), 32'h9999);
        check("rst last", 32'(o_last_bcd), 32'd0);
        check("rst counts", {24'd0, o_ok_cnt, o_fail_cnt}, 32'd0);
        check("rst pulses", {29'd0, o_timer_clr, o_start, o_stop}, 32'd0);
        check("rst done", 32'(o_session_done), 32'd0);
        i_reset = 1'b0;
        tick();

`ifdef REACTION_AUTO_RETRY_EN
        begin_session("rt");
        start_round("rt r1a");
        i_timer_state = 2'b01;
        tick();
        press_stop("rt early");
        i_btn = 1'b0;
        finish_round("rt r1a", 2'd1, 16'h9999);
        check("rt early fail", 32'(o_fail_cnt), 32'd1);
        start_round("rt r1b");
        check("rt replay round", 32'(o_round), 32'd1);
        i_timer_state = 2'b10;
        tick();
        finish_round("rt r1b", 2'd0, 16'h0200);
        check("rt ok1", 32'(o_ok_cnt), 32'd1);
        start_round("rt r2");
        check("rt round 2", 32'(o_round), 32'd2);
        finish_round("rt r2", 2'd0, 16'h0150);
        wait_done("rt");
        check("rt final round", 32'(o_round), 32'd2);
        check("rt final fail", 32'(o_fail_cnt), 32'd1);
        check("rt final ok", 32'(o_ok_cnt), 32'd2);
        check("rt final best", 32'(o_best_bcd), 32'h0150);
`else
        // Session 1: three clean rounds.
        begin_session("s1");
        start_round("s1 r1");
        i_timer_state = 2'b01;
        tick();
        i_timer_state = 2'b10;
        tick();
        finish_round("s1 r1", 2'd0, 16'h0245);
        check("s1 r1 best", 32'(o_best_bcd), 32'h0245);
        check("s1 r1 ok", 32'(o_ok_cnt), 32'd1);
        start_round("s1 r2");
        check("s1 r2 round", 32'(o_round), 32'd2);
        i_timer_state = 2'b10;
        tick();
        press_stop("s1 r2");
        i_btn = 1'b0;
        finish_round("s1 r2", 2'd0, 16'h0180);
        check("s1 r2 best", 32'(o_best_bcd), 32'h0180);
        start_round("s1 r3");
        finish_round("s1 r3", 2'd0, 16'h0312);
        wait_done("s1");
        check("s1 best", 32'(o_best_bcd), 32'h0180);
        check("s1 last", 32'(o_last_bcd), 32'h0312);
        check("s1 ok", 32'(o_ok_cnt), 32'd3);
        check("s1 fail", 32'(o_fail_cnt), 32'd0);
        check("s1 round", 32'(o_round), 32'd3);

        // Leaving S_DONE keeps the statistics until a new session starts.
        i_btn = 1'b1;
        tick();
        check("idle state", 32'(o_ctrl_state), 32'd0);
        check("idle round", 32'(o_round), 32'd0);
        check("idle best kept", 32'(o_best_bcd), 32'h0180);
        check("idle ok kept", 32'(o_ok_cnt), 32'd3);
        i_btn = 1'b0;
        tick();

        // Session 2: early round, slow round with a held button, reset mid-hold.
        begin_session("s2");
        start_round("s2 r1");
        i_timer_state = 2'b01;
        tick();
        press_stop("s2 early");
        i_btn = 1'b0;
        finish_round("s2 r1", 2'd1, 16'h9999);
        check("s2 early fail", 32'(o_fail_cnt), 32'd1);
        check("s2 early best", 32'(o_best_bcd), 32'h9999);
        check("s2 early ok", 32'(o_ok_cnt), 32'd0);
        i_btn = 1'b1;
        tick();
        tick();
        check("hold ignores btn", 32'(o_ctrl_state), 32'd5);
        check("hold no stop", 32'(o_stop), 32'd0);
        i_btn = 1'b0;

        start_round("s2 r2");
        i_timer_state = 2'b10;
        s0 = n_stops;
        i_btn = 1'b1;
        repeat (50) tick();
        finish_round("s2 r2", 2'd2, 16'h1000);
        check("held btn one stop", 32'(n_stops - s0), 32'd1);
        check("s2 slow fail", 32'(o_fail_cnt), 32'd2);
        check("s2 slow best", 32'(o_best_bcd), 32'h9999);
        check("s2 slow round", 32'(o_round), 32'd2);
        i_btn = 1'b0;

        i_reset = 1'b1;
        #1;
        check("async rst state", 32'(o_ctrl_state), 32'd0);
        check("async rst round", 32'(o_round), 32'd0);
        check("async rst fail", 32'(o_fail_cnt), 32'd0);
        tick();
        check("rst hold state", 32'(o_ctrl_state), 32'd0);
        check("rst hold best", 32'(o_best_bcd), 32'h9999);
        i_reset       = 1'b0;
        i_timer_state = 2'b00;
        tick();
        begin_session("s3");
        start_round("s3 r1");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
